msg_tx_arb: RTL and testbench
=============================

// Module: msg_tx_arb
// PURPOSE
//  Shares the single byte coder between N_SRC message controllers (time-mark, data, status).
//  Grants one source at a time via its tx_en, muxes its q/q_rdy to the coder and holds
//  the grant until that source's msg_end pulse. Enforces an inter-message gap.
//  Sits between the message controllers and the coder; source 0 is the time-mark controller.
// PARAMETERS
//  N_SRC        3     number of message sources (>=2); index 0 = highest priority
//  GAP_CYC      2     idle cycles with all tx_en low between messages (>=1)
//  TIMEOUT_CYC  4096  max cycles from grant to msg_end (used only with MSG_TIMEOUT_EN)
// PORTS
//  clk          in   1        system clock
//  rst_n        in   1        asynchronous reset, active low
//  req          in   N_SRC    per-source request to send a message (level)
//  tx_en        out  N_SRC    one-hot grant to sources; all-zero when no grant
//  src_q        in   8*N_SRC  source byte buses, source i at [8*i+7:8*i]
//  src_q_rdy    in   N_SRC    per-source byte-ready
//  src_msg_end  in   N_SRC    per-source one-cycle end-of-message pulse
//  cd_q         out  8        byte to coder
//  cd_q_rdy     out  1        byte-ready to coder
//  grant_id     out  clog2(N_SRC)  index of current grant (valid while busy)
//  busy         out  1        1 in GRANT or GAP
//  timeout_err  out  1        one-cycle pulse on message timeout
// BEHAVIOUR
//  - Reset (async): state IDLE; tx_en=0, cd_q=0, cd_q_rdy=0, grant_id=0, busy=0, timeout_err=0.
//  - States: IDLE -> GRANT -> GAP -> IDLE.
//  - IDLE: if |req, winner = lowest set index; next edge: tx_en[winner]=1, grant_id=winner,
//    state GRANT. req is sampled only in IDLE; no preemption.
//  - GRANT: cd_q = src_q[grant_id], cd_q_rdy = src_q_rdy[grant_id] (combinational mux gated
//    by GRANT; 0 otherwise). req changes ignored. src_msg_end[grant_id]=1 -> next edge
//    tx_en=0, state GAP, gap counter = GAP_CYC-1.
//  - src_msg_end on non-granted index: ignored in every state.
//  - GAP: tx_en=0 for exactly GAP_CYC cycles (lets source byte counters clear), then IDLE.
//    Arbitration in IDLE happens the cycle after GAP ends: first cycle of next tx_en is
//    GAP_CYC+2 cycles after the msg_end cycle.
//  - Simultaneous requests: fixed priority, lower index wins; a held lower-index req wins
//    again after every gap (starvation of higher indices is accepted by design).
//  - cd_busy is not routed through this block; sources see the coder directly.
// CONFIGURATION
//  - MSG_TIMEOUT_EN defined: cycle counter cleared on entry to GRANT; if it reaches
//    TIMEOUT_CYC without src_msg_end[grant_id], drop tx_en, pulse timeout_err 1 cycle,
//    go to GAP. msg_end on the same cycle as expiry wins (normal end, no error).
//  - Not defined: no counter, timeout_err tied 0, GRANT held until msg_end indefinitely.
// STRUCTURE
//  - State encoding localparams ARB_IDLE/ARB_GRANT/ARB_GAP go into msg_defs.vh next to
//    the marker/flag defines.
//  - Sub-module msg_prio_enc: N_SRC-bit fixed-priority encoder -> {valid, index}.
// TESTING
//  1. req=3'b010 -> tx_en=3'b010 at edge+1; cd_q tracks src_q[15:8], cd_q_rdy tracks
//     src_q_rdy[1]; msg_end[1] -> tx_en=0 next edge, busy=1 for 2 more cycles, then 0.
//  2. req=3'b110 same cycle -> grant 1 first; after msg_end + 2 gap cycles, grant 2.
//  3. Grant 2 active, req[0] rises -> no preemption; after msg_end[2] and gap, grant 0.
//  4. Grant 1 active, msg_end[0] and msg_end[2] pulsed -> tx_en stays 3'b010.
//  5. rst_n low mid-GRANT -> tx_en=0, cd_q=0, cd_q_rdy=0 immediately (no clock); IDLE.
//  6. MSG_TIMEOUT_EN, TIMEOUT_CYC=16, no msg_end -> timeout_err pulse at cycle 16 of
//     grant, then GAP; without macro, tx_en held for 100+ cycles, timeout_err=0.

Source files
------------

// File: rtl/msg_tx_arb_pkg.sv
`default_nettype none
// msg_tx_arb_pkg: arbiter state encoding shared by the message transmit arbiter.
package msg_tx_arb_pkg;

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_GRANT = 2'd1;
  localparam logic [1:0] ARB_GAP   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = ARB_IDLE,
    ST_GRANT = ARB_GRANT,
    ST_GAP   = ARB_GAP
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/msg_prio_enc.sv
`default_nettype none
// msg_prio_enc: N-bit fixed-priority encoder, lowest set index wins.
module msg_prio_enc #(
  parameter  int N  = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  vec_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  always_comb begin
    valid_o = |vec_i;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = IW'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/msg_tx_arb.sv
`default_nettype none
// msg_tx_arb: grants the shared byte coder to one message source at a time, with an idle gap.
// Optional MSG_TIMEOUT_EN: a grant with no msg_end within TIMEOUT_CYC cycles is aborted.
module msg_tx_arb
  import msg_tx_arb_pkg::*;
#(
  parameter  int N_SRC       = 3,
  parameter  int GAP_CYC     = 2,
  parameter  int TIMEOUT_CYC = 4096,
  localparam int IDW         = $clog2(N_SRC)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_SRC-1:0]   req,
  output logic [N_SRC-1:0]   tx_en,
  input  logic [8*N_SRC-1:0] src_q,
  input  logic [N_SRC-1:0]   src_q_rdy,
  input  logic [N_SRC-1:0]   src_msg_end,
  output logic [7:0]         cd_q,
  output logic               cd_q_rdy,
  output logic [IDW-1:0]     grant_id,
  output logic               busy,
  output logic               timeout_err
);

  localparam int GW = $clog2(GAP_CYC + 1);

  arb_state_e         state_q, state_d;
  logic [N_SRC-1:0]   tx_en_q, tx_en_d;
  logic [IDW-1:0]     grant_id_q, grant_id_d;
  logic [GW-1:0]      gap_cnt_q, gap_cnt_d;
  logic               win_valid;
  logic [IDW-1:0]     win_idx;
  logic [7:0]         sel_q;
  logic               sel_rdy;
  logic               sel_end;

  msg_prio_enc #(.N(N_SRC)) u_prio_enc (
    .vec_i   (req),
    .valid_o (win_valid),
    .idx_o   (win_idx)
  );

  always_comb begin
    sel_q   = '0;
    sel_rdy = 1'b0;
    sel_end = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant_id_q == IDW'(i)) begin
        sel_q   = src_q[8*i +: 8];
        sel_rdy = src_q_rdy[i];
        sel_end = src_msg_end[i];
      end
    end
  end

`ifdef MSG_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          timeout_err_q, timeout_err_d;
`endif

  always_comb begin
    state_d    = state_q;
    tx_en_d    = tx_en_q;
    grant_id_d = grant_id_q;
    gap_cnt_d  = gap_cnt_q;
`ifdef MSG_TIMEOUT_EN
    to_cnt_d      = to_cnt_q;
    timeout_err_d = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          state_d          = ST_GRANT;
          tx_en_d          = '0;
          tx_en_d[win_idx] = 1'b1;
          grant_id_d       = win_idx;
`ifdef MSG_TIMEOUT_EN
          to_cnt_d         = '0;
`endif
        end
      end
      ST_GRANT: begin
        // A real msg_end takes precedence over a timeout expiring on the same cycle.
        if (sel_end) begin
          state_d   = ST_GAP;
          tx_en_d   = '0;
          gap_cnt_d = GW'(GAP_CYC - 1);
        end
`ifdef MSG_TIMEOUT_EN
        else if (to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
          state_d       = ST_GAP;
          tx_en_d       = '0;
          gap_cnt_d     = GW'(GAP_CYC - 1);
          timeout_err_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
`endif
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) state_d = ST_IDLE;
        else                 gap_cnt_d = gap_cnt_q - GW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tx_en_q    <= '0;
      grant_id_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      tx_en_q    <= tx_en_d;
      grant_id_q <= grant_id_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

`ifdef MSG_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      to_cnt_q      <= to_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  // TIMEOUT_CYC only shapes the watchdog, which is absent in this build.
  if (TIMEOUT_CYC < 1) begin : g_timeout_unused
  end

  assign timeout_err = 1'b0;
`endif

  assign tx_en    = tx_en_q;
  assign grant_id = grant_id_q;
  assign busy     = (state_q != ST_IDLE);
  assign cd_q     = (state_q == ST_GRANT) ? sel_q : 8'h00;
  assign cd_q_rdy = (state_q == ST_GRANT) && sel_rdy;

endmodule
`default_nettype wire

// File: tb/tb_msg_tx_arb.sv
`default_nettype none
// tb_msg_tx_arb: directed and randomized checks of msg_tx_arb against a cycle-stamp model.
module tb_msg_tx_arb;

  localparam int N   = 3;
  localparam int GAP = 2;
  localparam int TO  = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req, tx_en, src_q_rdy, src_msg_end;
  logic [8*N-1:0] src_q;
  logic [7:0]     cd_q;
  logic           cd_q_rdy;
  logic [1:0]     grant_id;
  logic           busy, timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  msg_tx_arb #(.N_SRC(N), .GAP_CYC(GAP), .TIMEOUT_CYC(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .tx_en       (tx_en),
    .src_q       (src_q),
    .src_q_rdy   (src_q_rdy),
    .src_msg_end (src_msg_end),
    .cd_q        (cd_q),
    .cd_q_rdy    (cd_q_rdy),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model: a source owns the coder from grant to msg_end; the arbiter is idle again
  // only once GAP cycles have elapsed after the msg_end cycle.
  bit         m_owned;
  int         m_owner, m_end, m_start, m_to, cyc;
  logic [N-1:0] e_tx;
  logic       e_busy;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_owned = 1'b0;
      m_end   = -100;
      m_to    = -100;
      chk("rst_tx_en", tx_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cd_q", cd_q, 0);
      chk("rst_cd_q_rdy", cd_q_rdy, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_timeout_err", timeout_err, 0);
    end else begin
      e_tx = '0;
      if (m_owned) e_tx[m_owner] = 1'b1;
      e_busy = m_owned || (cyc > m_end && cyc <= m_end + GAP);
      chk("m_tx_en", tx_en, e_tx);
      chk("m_busy", busy, e_busy);
      chk("m_cd_q", cd_q, m_owned ? src_q[8*m_owner +: 8] : 8'h00);
      chk("m_cd_q_rdy", cd_q_rdy, m_owned ? src_q_rdy[m_owner] : 1'b0);
      chk("m_timeout_err", timeout_err, (cyc == m_to));
      if (e_busy) chk("m_grant_id", grant_id, m_owner);
      if (m_owned) begin
        if (src_msg_end[m_owner]) begin
          m_owned = 1'b0;
          m_end   = cyc;
        end
`ifdef MSG_TIMEOUT_EN
        else if (cyc - m_start == TO - 1) begin
          m_owned = 1'b0;
          m_end   = cyc;
          m_to    = cyc + 1;
        end
`endif
      end else if (cyc > m_end + GAP && req != '0) begin
        for (int i = N - 1; i >= 0; i--) if (req[i]) m_owner = i;
        m_owned = 1'b1;
        m_start = cyc + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic end_msg(input logic [N-1:0] ends, input logic [N-1:0] nreq);
    tick();
    src_msg_end = ends;
    req = nreq;
    tick();
    src_msg_end = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    req = '0;
    src_q = '0;
    src_q_rdy = '0;
    src_msg_end = '0;
    repeat (3) tick();
    rst_n = 1'b1;

    // Single request from source 1, byte mux and gap length.
    tick();
    req = 3'b010;
    src_q = 24'h33_A5_11;
    src_q_rdy = 3'b010;
    @(negedge clk);
    chk("t1_idle_tx_en", tx_en, 3'b000);
    tick();
    @(negedge clk);
    chk("t1_grant_tx_en", tx_en, 3'b010);
    chk("t1_cd_q", cd_q, 8'hA5);
    chk("t1_cd_q_rdy", cd_q_rdy, 1'b1);
    chk("t1_grant_id", grant_id, 2'd1);
    tick();
    src_q[15:8] = 8'h5C;
    src_q_rdy = 3'b101;
    @(negedge clk);
    chk("t1_cd_q_track", cd_q, 8'h5C);
    chk("t1_cd_q_rdy_track", cd_q_rdy, 1'b0);
    tick();
    src_msg_end = 3'b010;
    req = '0;
    @(negedge clk);
    chk("t1_end_cycle_tx_en", tx_en, 3'b010);
    tick();
    src_msg_end = '0;
    @(negedge clk);
    chk("t1_gap1_tx_en", tx_en, 3'b000);
    chk("t1_gap1_busy", busy, 1'b1);
    tick();
    @(negedge clk);
    chk("t1_gap2_busy", busy, 1'b1);
    tick();
    @(negedge clk);
    chk("t1_idle_busy", busy, 1'b0);

    // Simultaneous requests: lower index first, then index 2 after the gap.
    tick();
    req = 3'b110;
    tick();
    @(negedge clk);
    chk("t2_first_grant", tx_en, 3'b010);
    end_msg(3'b010, 3'b100);
    tick();
    tick();
    @(negedge clk);
    chk("t2_gap_end_idle", tx_en, 3'b000);
    tick();
    @(negedge clk);
    chk("t2_second_grant", tx_en, 3'b100);

    // No preemption by a higher-priority request.
    tick();
    req = 3'b101;
    repeat (3) begin
      tick();
      @(negedge clk);
      chk("t3_no_preempt", tx_en, 3'b100);
    end
    end_msg(3'b100, 3'b001);
    repeat (3) tick();
    @(negedge clk);
    chk("t3_grant0", tx_en, 3'b001);

    // msg_end of non-granted sources is ignored.
    end_msg(3'b001, 3'b010);
    repeat (3) tick();
    @(negedge clk);
    chk("t4_grant1", tx_en, 3'b010);
    tick();
    src_msg_end = 3'b101;
    req = '0;
    tick();
    src_msg_end = '0;
    @(negedge clk);
    chk("t4_foreign_end_ignored", tx_en, 3'b010);
    end_msg(3'b010, 3'b000);

    // Randomized traffic, including stray msg_end pulses.
    repeat (600) begin
      tick();
      req = N'($urandom_range(0, 7));
      src_q = 24'($urandom);
      src_q_rdy = N'($urandom_range(0, 7));
      for (int i = 0; i < N; i++) src_msg_end[i] = ($urandom_range(0, 5) == 0);
    end
    tick();
    req = '0;
    src_msg_end = 3'b111;
    tick();
    src_msg_end = '0;
    repeat (GAP + 2) tick();

    // Asynchronous reset in the middle of a grant.
    req = 3'b001;
    tick();
    req = '0;
    src_q = 24'hFF_FF_FF;
    src_q_rdy = 3'b111;
    #1;
    chk("t5_pre_reset_tx_en", tx_en, 3'b001);
    rst_n = 1'b0;
    #1;
    chk("t5_async_tx_en", tx_en, 3'b000);
    chk("t5_async_cd_q", cd_q, 8'h00);
    chk("t5_async_cd_q_rdy", cd_q_rdy, 1'b0);
    chk("t5_async_busy", busy, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("t5_after_reset_busy", busy, 1'b0);

    // Long grant with no msg_end.
    tick();
    req = 3'b010;
    tick();
    req = '0;
    repeat (120) tick();
    @(negedge clk);
`ifdef MSG_TIMEOUT_EN
    chk("t6_timed_out_tx_en", tx_en, 3'b000);
`else
    chk("t6_held_tx_en", tx_en, 3'b010);
`endif
    end_msg(3'b010, 3'b000);
    repeat (GAP + 3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
